// File: rtl/mux_arb_stream_if.sv
// mux_arb_stream_if
//   Bundles the WAYS producer streams and the single consumer stream seen by
//   mux_arb_stream.
//   Optional feature macro: MUX_ARB_STREAM_LOCK_EN adds in_last/out_last.
//
// Signals
//   in_data   [WAYS*WIDTH] packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  [WAYS]       per-channel valid
//   in_ready  [WAYS]       per-channel ready, one-hot or zero
//   in_last   [WAYS]       per-channel end-of-packet (lock build only)
//   out_data  [WIDTH]      registered selected word
//   out_sel   [SEL_W]      source channel of out_data
//   out_valid              output stage holds a word
//   out_ready              consumer accepts the word
//   out_last               end-of-packet of out_data (lock build only)
//
// Modports
//   master : producers plus consumer (drives inputs, observes outputs)
//   slave  : the arbiter
interface mux_arb_stream_if #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8
);
  localparam int SEL_W = $clog2(WAYS);

  logic [WAYS*WIDTH-1:0] in_data;
  logic [WAYS-1:0]       in_valid;
  logic [WAYS-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_valid;
  logic                  out_ready;
`ifdef MUX_ARB_STREAM_LOCK_EN
  logic [WAYS-1:0]       in_last;
  logic                  out_last;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_sel, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_sel, out_valid, out_last
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
`endif

endinterface

// File: rtl/mux_arb_stream.sv
// mux_arb_stream
//   Arbitrates WAYS valid/ready input streams of WIDTH bits onto a single
//   registered output stage, tagging each word with its source channel.
//   MODE=0 : round-robin, search starts at the channel after the last winner.
//   MODE=1 : fixed priority, lowest index wins.
//   The output stage refills in the cycle it drains (1 word/cycle).
//
//   Optional feature macro: MUX_ARB_STREAM_LOCK_EN
//     Adds in_last/out_last. A winner keeps the grant until it transfers a
//     beat with in_last set; the round-robin pointer only moves on that beat.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous, active-low reset
//   bus    mux_arb_stream_if.slave (in_data, in_valid, in_ready, out_data,
//          out_sel, out_valid, out_ready [, in_last, out_last])
module mux_arb_stream #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int MODE  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_arb_stream_if.slave bus
);

  localparam int               SEL_W    = $clog2(WAYS);
  localparam logic [SEL_W:0]   WAYS_EXT = (SEL_W+1)'(WAYS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WAYS-1);

  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  ptr_next;
  logic [SEL_W-1:0]  base;
  logic [WAYS-1:0]   req;
  logic [2*WAYS-1:0] req_dbl;
  logic [WAYS-1:0]   req_rot;
  logic [SEL_W:0]    idx_sum;
  logic [SEL_W-1:0]  grant;
  logic              found;
  logic              any_req;
  logic              load_en;
  logic              xfer;
  logic [WIDTH-1:0]  grant_data;
  logic [WAYS-1:0]   ready_vec;

`ifdef MUX_ARB_STREAM_LOCK_EN
  logic              lock;
  logic [SEL_W-1:0]  lock_idx;
  logic [WAYS-1:0]   lock_mask;
  logic              grant_last;

  // While locked, every channel except the locked one is invisible.
  always_comb begin
    lock_mask = '0;
    for (int i = 0; i < WAYS; i++) begin
      lock_mask[i] = (lock_idx == SEL_W'(i));
    end
  end

  assign req = lock ? (bus.in_valid & lock_mask) : bus.in_valid;
`else
  assign req = bus.in_valid;
`endif

  assign any_req = |req;
  assign load_en = !bus.out_valid || bus.out_ready;
  assign xfer    = load_en && any_req;

  // Rotate the request vector so the search always starts at bit 0; the
  // winner's offset is then added back onto the base, modulo WAYS.
  assign base    = (MODE == 1) ? '0 : ptr;
  assign req_dbl = {req, req} >> base;
  assign req_rot = req_dbl[WAYS-1:0];

  always_comb begin
    grant   = '0;
    found   = 1'b0;
    idx_sum = '0;
    for (int j = 0; j < WAYS; j++) begin
      if (!found && req_rot[j]) begin
        found   = 1'b1;
        idx_sum = {1'b0, base} + (SEL_W+1)'(j);
        if (idx_sum >= WAYS_EXT) begin
          idx_sum = idx_sum - WAYS_EXT;
        end
        grant = idx_sum[SEL_W-1:0];
      end
    end
  end

  // Explicit wrap so non-power-of-two WAYS never leaves ptr out of range.
  assign ptr_next = (grant == LAST_IDX) ? '0 : grant + SEL_W'(1);

  always_comb begin
    grant_data = '0;
    ready_vec  = '0;
`ifdef MUX_ARB_STREAM_LOCK_EN
    grant_last = 1'b0;
`endif
    for (int i = 0; i < WAYS; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data   = bus.in_data[i*WIDTH +: WIDTH];
        ready_vec[i] = xfer;
`ifdef MUX_ARB_STREAM_LOCK_EN
        grant_last   = bus.in_last[i];
`endif
      end
    end
  end

  assign bus.in_ready = ready_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      ptr           <= '0;
    end else if (load_en) begin
      bus.out_valid <= any_req;
      if (any_req) begin
        bus.out_data <= grant_data;
        bus.out_sel  <= grant;
`ifndef MUX_ARB_STREAM_LOCK_EN
        ptr          <= ptr_next;
`else
        if (grant_last) begin
          ptr <= ptr_next;
        end
`endif
      end
    end
  end

`ifdef MUX_ARB_STREAM_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock         <= 1'b0;
      lock_idx     <= '0;
      bus.out_last <= 1'b0;
    end else if (xfer) begin
      bus.out_last <= grant_last;
      lock         <= !grant_last;
      lock_idx     <= grant;
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb_stream.sv
module tb_mux_arb_stream;

`ifdef MUX_ARB_STREAM_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_arb_stream_if #(.WIDTH(16), .WAYS(8)) bus_rr8 ();
  mux_arb_stream_if #(.WIDTH(16), .WAYS(8)) bus_fp8 ();
  mux_arb_stream_if #(.WIDTH(16), .WAYS(5)) bus_rr5 ();

  mux_arb_stream #(.WIDTH(16), .WAYS(8), .MODE(0)) u_rr8 (.clk(clk), .rst_n(rst_n), .bus(bus_rr8));
  mux_arb_stream #(.WIDTH(16), .WAYS(8), .MODE(1)) u_fp8 (.clk(clk), .rst_n(rst_n), .bus(bus_fp8));
  mux_arb_stream #(.WIDTH(16), .WAYS(5), .MODE(0)) u_rr5 (.clk(clk), .rst_n(rst_n), .bus(bus_rr5));

  int errors = 0;
  int checks = 0;

  // active DUT: 0 = rr8, 1 = fp8, 2 = rr5
  int cur = 0;
  int cur_ways = 8;
  int cur_mode = 0;

  logic [15:0] dat [8];

  // reference model: contents of the output stage plus arbitration memory
  int m_valid, m_data, m_sel, m_ptr, m_lock, m_lidx, m_last;

  logic [7:0]  obs_ready;
  logic        obs_valid;
  logic [15:0] obs_data;
  int          obs_sel;
  logic        obs_last;

  function automatic logic [7:0] ways_mask();
    return (cur_ways == 5) ? 8'h1F : 8'hFF;
  endfunction

  // Winner from the rules: locked channel only, else first valid channel
  // scanning upward from the pointer (or from 0 in fixed priority), modulo WAYS.
  function automatic int ref_grant(logic [7:0] v);
    int start, i;
    if (m_lock != 0) return v[m_lidx] ? m_lidx : -1;
    start = (cur_mode == 1) ? 0 : m_ptr;
    for (int k = 0; k < cur_ways; k++) begin
      i = (start + k) % cur_ways;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_ready(logic [7:0] v, logic rdy);
    int g;
    g = ref_grant(v & ways_mask());
    if (g >= 0 && (m_valid == 0 || rdy)) return 8'h01 << g;
    return 8'h00;
  endfunction

  task automatic model_edge(logic [7:0] v, logic rdy, logic [7:0] lst);
    int g;
    g = ref_grant(v & ways_mask());
    if (m_valid == 0 || rdy) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = int'(dat[g]);
        m_sel   = g;
        m_last  = int'(lst[g]);
        if (LOCK_ON && !lst[g]) begin
          m_lock = 1;
          m_lidx = g;
        end else begin
          m_lock = 0;
          m_ptr  = (g + 1) % cur_ways;
        end
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic set_cfg(int which);
    cur      = which;
    cur_ways = (which == 2) ? 5 : 8;
    cur_mode = (which == 1) ? 1 : 0;
  endtask

  task automatic apply(logic [7:0] v, logic rdy, logic [7:0] lst);
    logic [127:0] d8;
    logic [79:0]  d5;
    for (int i = 0; i < 8; i++) d8[i*16 +: 16] = dat[i];
    for (int i = 0; i < 5; i++) d5[i*16 +: 16] = dat[i];
    bus_rr8.in_data   = d8;
    bus_fp8.in_data   = d8;
    bus_rr5.in_data   = d5;
    bus_rr8.in_valid  = (cur == 0) ? v : 8'h00;
    bus_fp8.in_valid  = (cur == 1) ? v : 8'h00;
    bus_rr5.in_valid  = (cur == 2) ? v[4:0] : 5'h00;
    bus_rr8.out_ready = (cur == 0) ? rdy : 1'b1;
    bus_fp8.out_ready = (cur == 1) ? rdy : 1'b1;
    bus_rr5.out_ready = (cur == 2) ? rdy : 1'b1;
`ifdef MUX_ARB_STREAM_LOCK_EN
    bus_rr8.in_last = lst;
    bus_fp8.in_last = lst;
    bus_rr5.in_last = lst[4:0];
`endif
  endtask

  task automatic sample();
    obs_last = 1'b0;
    case (cur)
      0: begin
        obs_ready = bus_rr8.in_ready;
        obs_valid = bus_rr8.out_valid;
        obs_data  = bus_rr8.out_data;
        obs_sel   = int'(bus_rr8.out_sel);
`ifdef MUX_ARB_STREAM_LOCK_EN
        obs_last  = bus_rr8.out_last;
`endif
      end
      1: begin
        obs_ready = bus_fp8.in_ready;
        obs_valid = bus_fp8.out_valid;
        obs_data  = bus_fp8.out_data;
        obs_sel   = int'(bus_fp8.out_sel);
`ifdef MUX_ARB_STREAM_LOCK_EN
        obs_last  = bus_fp8.out_last;
`endif
      end
      default: begin
        obs_ready = {3'b000, bus_rr5.in_ready};
        obs_valid = bus_rr5.out_valid;
        obs_data  = bus_rr5.out_data;
        obs_sel   = int'(bus_rr5.out_sel);
`ifdef MUX_ARB_STREAM_LOCK_EN
        obs_last  = bus_rr5.out_last;
`endif
      end
    endcase
  endtask

  // Drive at the falling edge, settle, observe the combinational ready.
  task automatic pre_edge(logic [7:0] v, logic rdy, logic [7:0] lst);
    @(negedge clk);
    apply(v, rdy, lst);
    #1;
    sample();
  endtask

  // Advance the DUT and the model through one rising edge, then observe.
  task automatic post_edge(logic [7:0] v, logic rdy, logic [7:0] lst);
    @(posedge clk);
    model_edge(v, rdy, lst);
    #1;
    sample();
  endtask

  task automatic do_reset(int which);
    set_cfg(which);
    rst_n = 1'b0;
    apply(8'h00, 1'b1, 8'hFF);
    m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    m_lock = 0; m_lidx = 0; m_last = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic seq_data();
    for (int i = 0; i < 8; i++) dat[i] = 16'h1000 + 16'(i);
  endtask

  task automatic test_reset();
    // Power-on state before any clock edge.
    set_cfg(0);
    seq_data();
    rst_n = 1'b0;
    apply(8'h00, 1'b1, 8'hFF);
    #2;
    checks++;
    if (bus_rr8.out_valid !== 1'b0 || bus_fp8.out_valid !== 1'b0 || bus_rr5.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_por_valid: got %b%b%b, want 000", bus_rr8.out_valid, bus_fp8.out_valid, bus_rr5.out_valid);
    end
    // Load 0xBEEF, hold it with backpressure, then assert reset mid-cycle.
    do_reset(0);
    dat[5] = 16'hBEEF;
    pre_edge(8'h20, 1'b0, 8'hFF);
    post_edge(8'h20, 1'b0, 8'hFF);
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL reset_preload: got valid=%b data=%h, want 1 beef", obs_valid, obs_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    sample();
    checks++;
    if (obs_valid !== 1'b0 || obs_data !== 16'h0000 || obs_sel !== 0) begin
      errors++;
      $display("FAIL reset_async: got valid=%b data=%h sel=%0d, want 0 0000 0", obs_valid, obs_data, obs_sel);
    end
    do_reset(0);
    seq_data();
  endtask

  task automatic test_rr_all_valid();
    int hits [8];
    do_reset(0);
    seq_data();
    for (int i = 0; i < 8; i++) hits[i] = 0;
    for (int k = 0; k < 9; k++) begin
      pre_edge(8'hFF, 1'b1, 8'hFF);
      if (k == 0) begin
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 8'h01) begin
          errors++;
          $display("FAIL rr_first: got valid=%b ready=%h, want 0 01", obs_valid, obs_ready);
        end
      end
      post_edge(8'hFF, 1'b1, 8'hFF);
      checks++;
      if (obs_valid !== 1'b1 || obs_sel !== (k % 8) || obs_data !== 16'h1000 + 16'(k % 8)) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got valid=%b sel=%0d data=%h, want 1 %0d %h", k, obs_valid, obs_sel, obs_data, k % 8, 16'h1000 + 16'(k % 8));
      end
      if (k < 8 && obs_sel >= 0 && obs_sel < 8) hits[obs_sel]++;
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hits[i] !== 1) begin
        errors++;
        $display("FAIL rr_fair[%0d]: got %0d grants in 8 transfers, want 1", i, hits[i]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset(1);
    seq_data();
    for (int k = 0; k < 4; k++) begin
      pre_edge(8'hA4, 1'b1, 8'hFF);
      checks++;
      if (obs_ready !== 8'h04) begin
        errors++;
        $display("FAIL fp_ready[%0d]: got %h, want 04", k, obs_ready);
      end
      post_edge(8'hA4, 1'b1, 8'hFF);
      checks++;
      if (obs_valid !== 1'b1 || obs_sel !== 2 || obs_data !== 16'h1002) begin
        errors++;
        $display("FAIL fp_out[%0d]: got valid=%b sel=%0d data=%h, want 1 2 1002", k, obs_valid, obs_sel, obs_data);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(0);
    seq_data();
    pre_edge(8'h20, 1'b1, 8'hFF);
    post_edge(8'h20, 1'b1, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      pre_edge(8'hFF, 1'b0, 8'hFF);
      checks++;
      if (obs_ready !== 8'h00) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %h, want 00", k, obs_ready);
      end
      post_edge(8'hFF, 1'b0, 8'hFF);
      checks++;
      if (obs_valid !== 1'b1 || obs_data !== 16'h1005 || obs_sel !== 5) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h sel=%0d, want 1 1005 5", k, obs_valid, obs_data, obs_sel);
      end
    end
    pre_edge(8'hFF, 1'b1, 8'hFF);
    checks++;
    if (obs_ready !== 8'h40) begin
      errors++;
      $display("FAIL bp_release_ready: got %h, want 40", obs_ready);
    end
    post_edge(8'hFF, 1'b1, 8'hFF);
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 16'h1006 || obs_sel !== 6) begin
      errors++;
      $display("FAIL bp_release_load: got valid=%b data=%h sel=%0d, want 1 1006 6", obs_valid, obs_data, obs_sel);
    end
  endtask

  task automatic test_rr5_wrap();
    int want [4] = '{4, 0, 4, 0};
    do_reset(2);
    seq_data();
    pre_edge(8'h08, 1'b1, 8'hFF);
    post_edge(8'h08, 1'b1, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      pre_edge(8'h11, 1'b1, 8'hFF);
      post_edge(8'h11, 1'b1, 8'hFF);
      checks++;
      if (obs_valid !== 1'b1 || obs_sel !== want[k]) begin
        errors++;
        $display("FAIL rr5_wrap[%0d]: got valid=%b sel=%0d, want 1 %0d", k, obs_valid, obs_sel, want[k]);
      end
    end
  endtask

`ifdef MUX_ARB_STREAM_LOCK_EN
  task automatic test_lock();
    int          want_sel [4] = '{3, 3, 3, 1};
    logic [7:0]  lst_seq  [4] = '{8'hF7, 8'hF7, 8'hFF, 8'hFF};
    logic [3:0]  want_last;
    want_last = 4'b1100;
    do_reset(0);
    seq_data();
    pre_edge(8'h04, 1'b1, 8'hFF);
    post_edge(8'h04, 1'b1, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      pre_edge(8'h0A, 1'b1, lst_seq[k]);
      post_edge(8'h0A, 1'b1, lst_seq[k]);
      checks++;
      if (obs_valid !== 1'b1 || obs_sel !== want_sel[k] || obs_last !== want_last[k]) begin
        errors++;
        $display("FAIL lock_beat[%0d]: got valid=%b sel=%0d last=%b, want 1 %0d %b", k, obs_valid, obs_sel, obs_last, want_sel[k], want_last[k]);
      end
    end
  endtask
`endif

  task automatic test_random(int which);
    logic [7:0]  v, lst, er;
    logic        rdy;
    do_reset(which);
    for (int k = 0; k < 150; k++) begin
      for (int i = 0; i < 8; i++) dat[i] = 16'($urandom);
      v   = 8'($urandom) & 8'($urandom_range(0, 1) ? 8'hFF : $urandom);
      v   = v & ways_mask();
      rdy = ($urandom_range(0, 3) != 0);
      lst = ($urandom_range(0, 2) != 0) ? 8'hFF : 8'($urandom);
      pre_edge(v, rdy, lst);
      er = exp_ready(v, rdy);
      checks++;
      if (obs_ready !== er) begin
        errors++;
        $display("FAIL rand%0d_ready[%0d]: got %h, want %h (valid=%h)", which, k, obs_ready, er, v);
      end
      post_edge(v, rdy, lst);
      checks++;
      if (obs_valid !== m_valid[0] ||
          (m_valid != 0 && (obs_data !== 16'(m_data) || obs_sel !== m_sel ||
                            (LOCK_ON && obs_last !== m_last[0])))) begin
        errors++;
        $display("FAIL rand%0d_out[%0d]: got valid=%b data=%h sel=%0d last=%b, want %0d %h %0d %0d",
                 which, k, obs_valid, obs_data, obs_sel, obs_last, m_valid, 16'(m_data), m_sel, m_last);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr_all_valid();
    test_fixed_priority();
    test_backpressure();
    test_rr5_wrap();
`ifdef MUX_ARB_STREAM_LOCK_EN
    test_lock();
`endif
    test_random(0);
    test_random(1);
    test_random(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
